// File: rtl/regfile_param_pkg.sv
// regfile_param_pkg: shared FSM encoding and default geometry for the parametrised register file
package regfile_param_pkg;
    typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;
    localparam int WIDTH_D = 8;
    localparam int NREGS_D = 16;
    localparam int ABITS_D = 4;
endpackage

// File: rtl/regfile_param_if.sv
// regfile_param_if: decoder/ALU-side port bundle of the register file
interface regfile_param_if #(
    parameter int WIDTH = regfile_param_pkg::WIDTH_D,
    parameter int ABITS = regfile_param_pkg::ABITS_D
);
    logic             we3;
    logic [ABITS-1:0] ra1;
    logic [ABITS-1:0] ra2;
    logic [ABITS-1:0] wa3;
    logic [WIDTH-1:0] wd3;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             busy;
    logic             wlost;
    modport master (output we3, ra1, ra2, wa3, wd3, input rd1, rd2, busy, wlost);
    modport slave  (input we3, ra1, ra2, wa3, wd3, output rd1, rd2, busy, wlost);
endinterface

// File: rtl/regfile_param_clr_seq.sv
// regfile_param_clr_seq: post-reset sequencer that sweeps a zero through every register once
module regfile_param_clr_seq import regfile_param_pkg::*; #(
    parameter int NREGS = NREGS_D,
    parameter int ABITS = ABITS_D
) (
    input  logic             clk,
    input  logic             reset,
    output logic             o_busy,
    output logic             o_swe,
    output logic [ABITS-1:0] o_sa
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [ABITS-1:0] r_cnt;
    logic [ABITS-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // cnt wraps to 0 by itself on the last sweep edge since NREGS == 2**ABITS
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == ST_CLEAR) begin
            w_cnt_nxt   = r_cnt + 1'b1;
            w_state_nxt = (r_cnt == ABITS'(NREGS - 1)) ? ST_READY : ST_CLEAR;
        end
    end

    assign o_busy = (r_state == ST_CLEAR);
    assign o_swe  = o_busy & ~reset;
    assign o_sa   = r_cnt;
endmodule

// File: rtl/regfile_param.sv
// regfile_param: WIDTH x NREGS two-read/one-write register file, r0 hardwired to zero, swept clear after reset
module regfile_param import regfile_param_pkg::*; #(
    parameter int WIDTH  = WIDTH_D,
    parameter int NREGS  = NREGS_D,
    parameter int ABITS  = ABITS_D,
    parameter int BYPASS = 1
) (
    input  logic           clk,
    input  logic           reset,
    regfile_param_if.slave bus
);
    logic [WIDTH-1:0] r_regb [NREGS];
    logic             r_wlost;
    logic             w_busy;
    logic             w_swe;
    logic [ABITS-1:0] w_sa;
    logic             w_we;
    logic [ABITS-1:0] w_wa;
    logic [WIDTH-1:0] w_wd;

    regfile_param_clr_seq #(.NREGS(NREGS), .ABITS(ABITS)) u_clr (
        .clk    (clk),
        .reset  (reset),
        .o_busy (w_busy),
        .o_swe  (w_swe),
        .o_sa   (w_sa)
    );

    // sweep owns the write port while busy; external writes only land in READY and never on r0
    assign w_we = w_swe | (bus.we3 & ~w_busy & ~reset & (bus.wa3 != '0));
    assign w_wa = w_busy ? w_sa : bus.wa3;
    assign w_wd = w_busy ? '0 : bus.wd3;

    always_ff @(posedge clk) begin
        if (w_we) r_regb[w_wa] <= w_wd;
    end

    always_ff @(posedge clk) begin
        r_wlost <= reset ? 1'b0 : (bus.we3 & w_busy);
    end

    assign bus.rd1 = (bus.ra1 == '0 || w_busy) ? '0 :
                     (BYPASS != 0 && bus.we3 && bus.wa3 == bus.ra1) ? bus.wd3 : r_regb[bus.ra1];
    assign bus.rd2 = (bus.ra2 == '0 || w_busy) ? '0 :
                     (BYPASS != 0 && bus.we3 && bus.wa3 == bus.ra2) ? bus.wd3 : r_regb[bus.ra2];
    assign bus.busy  = w_busy;
    assign bus.wlost = r_wlost;
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: vector table plus scoreboard checks of bypass, r0, clear sweep and wide geometry
module tb_regfile_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_param_if #(.WIDTH(8),  .ABITS(4)) a();
    regfile_param_if #(.WIDTH(8),  .ABITS(4)) b();
    regfile_param_if #(.WIDTH(16), .ABITS(5)) c();

    regfile_param #(.WIDTH(8),  .NREGS(16), .ABITS(4), .BYPASS(1)) dut_a (.clk(clk), .reset(rst), .bus(a.slave));
    regfile_param #(.WIDTH(8),  .NREGS(16), .ABITS(4), .BYPASS(0)) dut_b (.clk(clk), .reset(rst), .bus(b.slave));
    regfile_param #(.WIDTH(16), .NREGS(32), .ABITS(5), .BYPASS(1)) dut_c (.clk(clk), .reset(rst), .bus(c.slave));

    typedef struct {string nm; logic [15:0] v;} exp_t;
    typedef struct {logic we; logic [3:0] r1, r2, w; logic [7:0] d, a1, a2, b1, b2;} vec_t;

    exp_t sbq[$];
    vec_t tv[11];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input logic [15:0] v);
        exp_t e;
        e.nm = nm;
        e.v  = v;
        sbq.push_back(e);
    endtask

    task automatic pop(input logic [15:0] act);
        exp_t e;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got %h with no expectation queued", act);
        end else begin
            e = sbq.pop_front();
            chk(e.nm, act, e.v);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input logic we, input logic [3:0] r1, input logic [3:0] r2,
                       input logic [3:0] w, input logic [7:0] d);
        a.we3 = we; a.ra1 = r1; a.ra2 = r2; a.wa3 = w; a.wd3 = d;
        b.we3 = we; b.ra1 = r1; b.ra2 = r2; b.wa3 = w; b.wd3 = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, na, nc;
        tv[0]  = '{1'b1, 4'd7,  4'd0,  4'd7,  8'h3C, 8'h3C, 8'h00, 8'h00, 8'h00};
        tv[1]  = '{1'b0, 4'd7,  4'd7,  4'd0,  8'h00, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
        tv[2]  = '{1'b1, 4'd0,  4'd7,  4'd0,  8'hFF, 8'h00, 8'h3C, 8'h00, 8'h3C};
        tv[3]  = '{1'b0, 4'd0,  4'd0,  4'd0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tv[4]  = '{1'b1, 4'd3,  4'd7,  4'd3,  8'h11, 8'h11, 8'h3C, 8'h00, 8'h3C};
        tv[5]  = '{1'b1, 4'd3,  4'd3,  4'd3,  8'h22, 8'h22, 8'h22, 8'h11, 8'h11};
        tv[6]  = '{1'b0, 4'd3,  4'd15, 4'd0,  8'h00, 8'h22, 8'h00, 8'h22, 8'h00};
        tv[7]  = '{1'b1, 4'd15, 4'd3,  4'd15, 8'h80, 8'h80, 8'h22, 8'h00, 8'h22};
        tv[8]  = '{1'b0, 4'd15, 4'd1,  4'd0,  8'h00, 8'h80, 8'h00, 8'h80, 8'h00};
        tv[9]  = '{1'b1, 4'd2,  4'd1,  4'd1,  8'h5A, 8'h00, 8'h5A, 8'h00, 8'h00};
        tv[10] = '{1'b0, 4'd1,  4'd2,  4'd0,  8'h00, 8'h5A, 8'h00, 8'h5A, 8'h00};

        c.we3 = 1'b0; c.ra1 = '0; c.ra2 = '0; c.wa3 = '0; c.wd3 = '0;
        drv(1'b0, 4'd3, 4'd0, 4'd0, 8'h00);
        rst = 1'b1;
        repeat (3) step;
        #1;
        chk("rst_busy", 16'(a.busy), 16'h1);
        chk("rst_wlost", 16'(a.wlost), 16'h0);
        chk("rst_rd1", 16'(a.rd1), 16'h0);
        chk("rst_busy_c", 16'(c.busy), 16'h1);

        rst = 1'b0;
        drv(1'b1, 4'd5, 4'd0, 4'd5, 8'hAA);
        #1;
        chk("clr_rd1_busy", 16'(a.rd1), 16'h0);
        n = 0; na = 0; nc = 0;
        while ((a.busy || c.busy) && n < 100) begin
            step;
            n++;
            if (n == 1) begin
                #1;
                chk("wlost_set", 16'(a.wlost), 16'h1);
                drv(1'b0, 4'd5, 4'd0, 4'd0, 8'h00);
            end
            if (n == 2) chk("wlost_clr", 16'(a.wlost), 16'h0);
            if (!a.busy && na == 0) na = n;
            if (!c.busy && nc == 0) nc = n;
        end
        chk("busy_edges", 16'(na), 16'd16);
        chk("busy_edges_c", 16'(nc), 16'd32);

        for (int i = 0; i < 16; i++) begin
            drv(1'b0, 4'(i), 4'(15 - i), 4'd0, 8'h00);
            #1;
            chk("swept_rd1", 16'(a.rd1), 16'h0);
            chk("swept_rd2", 16'(a.rd2), 16'h0);
            step;
        end

        for (int i = 0; i < 11; i++) begin
            drv(tv[i].we, tv[i].r1, tv[i].r2, tv[i].w, tv[i].d);
            push("vec_a_rd1", 16'(tv[i].a1));
            push("vec_a_rd2", 16'(tv[i].a2));
            push("vec_b_rd1", 16'(tv[i].b1));
            push("vec_b_rd2", 16'(tv[i].b2));
            push("vec_wlost", 16'h0);
            #1;
            pop(16'(a.rd1));
            pop(16'(a.rd2));
            pop(16'(b.rd1));
            pop(16'(b.rd2));
            pop(16'(a.wlost));
            step;
        end

        for (int i = 1; i < 16; i++) begin
            drv(1'b1, 4'd0, 4'd0, 4'(i), 8'(i));
            step;
        end
        drv(1'b0, 4'd9, 4'd15, 4'd0, 8'h00);
        #1;
        chk("pre_rd9", 16'(a.rd1), 16'h09);
        chk("pre_rd15", 16'(a.rd2), 16'h0F);
        rst = 1'b1;
        step;
        rst = 1'b0;
        repeat (9) step;
        chk("mid_busy", 16'(a.busy), 16'h1);
        drv(1'b1, 4'd0, 4'd0, 4'd4, 8'h44);
        rst = 1'b1;
        step;
        rst = 1'b0;
        drv(1'b0, 4'd0, 4'd0, 4'd0, 8'h00);
        chk("rst_wlost_force", 16'(a.wlost), 16'h0);
        n = 0;
        while (a.busy && n < 100) begin
            step;
            n++;
        end
        chk("restart_edges", 16'(n), 16'd16);
        for (int i = 0; i < 16; i++) begin
            drv(1'b0, 4'(i), 4'(i), 4'd0, 8'h00);
            #1;
            chk("restart_rd1", 16'(a.rd1), 16'h0);
            chk("restart_rd2", 16'(a.rd2), 16'h0);
            step;
        end

        n = 0;
        while (c.busy && n < 100) begin
            step;
            n++;
        end
        chk("c_ready", 16'(c.busy), 16'h0);
        c.we3 = 1'b1; c.wa3 = 5'd31; c.wd3 = 16'hBEEF; c.ra1 = 5'd31; c.ra2 = 5'd31;
        #1;
        chk("c_byp_rd1", c.rd1, 16'hBEEF);
        chk("c_byp_rd2", c.rd2, 16'hBEEF);
        step;
        c.we3 = 1'b1; c.wa3 = 5'd16; c.wd3 = 16'h1234; c.ra1 = 5'd31; c.ra2 = 5'd15;
        #1;
        chk("c_rd31", c.rd1, 16'hBEEF);
        chk("c_rd15", c.rd2, 16'h0000);
        step;
        c.we3 = 1'b0; c.ra1 = 5'd16; c.ra2 = 5'd31;
        #1;
        chk("c_rd16", c.rd1, 16'h1234);
        chk("c_rd31_again", c.rd2, 16'hBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised successor to the 16×8 two-read/one-write register file of the datapath. Width and depth are configurable, and register 0 stays hardwired to zero. The file is cleared at reset by an internal sweep sequencer, which replaces file-based preload. An optional same-cycle write-to-read bypass is available. The block sits between the decoder's register-address fields and the ALU operand muxes, and is a drop-in replacement when WIDTH=8, NREGS=16, ABITS=4.

## Interface
- WIDTH, 8: data width of each register.
- NREGS, 16: number of registers; power of two, ≥2.
- ABITS, 4: address width; must equal log2(NREGS).
- BYPASS, 1: 1 makes a read of the register being written return wd3 in the same cycle; 0 returns the old contents.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset; starts the clear sweep.
- we3  in  1  write enable.
- ra1, ra2  in  ABITS  read addresses.
- wa3  in  ABITS  write address.
- wd3  in  WIDTH  write data.
- rd1, rd2  out  WIDTH  combinational read data.
- busy  out  1  high while the clear sweep runs; reset value 1.
- wlost  out  1  registered one-cycle pulse: a write was dropped in the previous cycle; reset value 0.

## Operation
- There are two FSM states, CLEAR and READY.
- Reset:
  - Reset sampled high at a rising edge sets state=CLEAR, cnt=0 and wlost=0.
  - While reset is held, cnt stays 0 and busy stays 1.
- CLEAR:
  - Each edge with reset low writes 0 to regb[cnt], then increments cnt.
  - At the edge that clears regb[NREGS-1], state becomes READY and cnt wraps to 0.
  - External writes are discarded.
  - rd1 and rd2 return 0.
- READY:
  - An edge with we3=1 and wa3≠0 writes wd3 to regb[wa3].
  - Writes to address 0 are silently discarded; they do not set wlost.
- Reads:
  - rdN = 0 if raN==0 or busy=1.
  - Otherwise, if BYPASS=1, we3=1 and wa3==raN, rdN = wd3.
  - Otherwise rdN = regb[raN].
  - ra1==ra2 is legal; both ports return the same value.
- wlost:
  - Asserted at the edge following a cycle with we3=1 and busy=1.
  - Cleared at the next edge unless the condition repeats.
  - Forced to 0 on reset.
- Reset mid-sweep restarts the sweep at cnt=0.
- Reset during READY discards any pending write and re-enters CLEAR.

## Timing
- Write latency: data is visible through the array at the first edge after it is presented.
- With BYPASS=1, data is also visible combinationally in the same cycle.
- Sweep duration: exactly NREGS edges after reset is deasserted.
  - busy falls after the NREGS-th edge.
  - The first accepted write is the one presented in the cycle after that.
- busy and wlost are registered and glitch-free.
- rd1 and rd2 have a combinational path from ra*, and from wa3/wd3/we3 when BYPASS=1.

## Structure
- The shared package holds:
  - the state encoding ST_CLEAR=1'b0 and ST_READY=1'b1;
  - the default constants WIDTH_D=8, NREGS_D=16 and ABITS_D=4.
- One sub-module, clr_seq, holds the state register, cnt, busy and the sweep write strobe and address.
- The storage array, the write mux (sweep vs. external), the read/bypass logic and the wlost flop live in the top module.

## Test plan
- Reset held for 3 cycles, then released with WIDTH=8, NREGS=16: busy=1 for exactly 16 edges after release, then 0. All 16 addresses read 0x00.
- During CLEAR, we3=1, wa3=5, wd3=0xAA: wlost=1 on the next cycle. Once READY, ra1=5 reads 0x00.
- READY, we3=1, wa3=7, wd3=0x3C, ra1=7, ra2=0:
  - BYPASS=1: rd1=0x3C in the same cycle.
  - BYPASS=0: rd1=0x00 in that cycle, then 0x3C after the edge.
  - rd2=0x00 in both cases.
- Write wa3=0, wd3=0xFF: ra1=0 reads 0x00 and wlost stays 0.
- Write regs 1..15 with value = address, then assert reset at sweep cnt=9 and release: the sweep restarts and busy lasts 16 more edges. All registers then read 0.
- WIDTH=16, NREGS=32, ABITS=5: write 0xBEEF to reg 31 and read it on both ports, then 0xBEEF. Busy lasts 32 edges.
